// File: rtl/keypad_scanner.sv
// keypad_scanner: row-scanning front end for a 4x4 keypad with press/release debounce.
// Ports: clk, reset (async active-low), col[3:0] raw columns in, row[3:0] one-hot drive,
//   row_idx[1:0] driven row, key_code[3:0] {row,col} of last accepted key,
//   key_valid one-cycle pulse per accepted press, key_held high until release accepted.
// Option: KEYSCAN_MULTI_REJECT_EN rejects multi-column presses in SCAN/PRESS_DB.
module keypad_scanner #(
  parameter int SCAN_DIV        = 16,
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic [1:0] row_idx,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  typedef enum logic [1:0] {
    SCAN,
    PRESS_DB,
    HELD,
    REL_DB
  } state_t;

  localparam logic [CNT_W-1:0] LP_SCAN_TC = CNT_W'(SCAN_DIV - 1);
  // Entry sample counts as the first, so acceptance fires at count N-2.
  localparam logic [CNT_W-1:0] LP_DEB_TC  = CNT_W'(DEBOUNCE_CYCLES - 2);
  localparam logic [CNT_W-1:0] LP_BLANK   = CNT_W'(2);

  state_t           r_state, w_state_nxt;
  logic [3:0]       r_sync1, r_col_s;
  logic [CNT_W-1:0] r_scan_cnt, w_scan_nxt;
  logic [CNT_W-1:0] r_deb_cnt, w_deb_nxt;
  logic [1:0]       r_row_idx, w_row_idx_nxt;
  logic [3:0]       r_row;
  logic [3:0]       r_cand, w_cand_nxt;
  logic [3:0]       r_code, w_code_nxt;
  logic             r_valid, w_valid_nxt;
  logic             r_held, w_held_nxt;
  logic             w_press_ok, w_match, w_mon;
  logic [1:0]       w_cand_idx;

  function automatic logic [1:0] f_enc(input logic [3:0] c);
    logic [1:0] v;
    v = 2'd0;
    priority case (1'b1)
      c[3]:    v = 2'd3;
      c[2]:    v = 2'd2;
      c[1]:    v = 2'd1;
      default: v = 2'd0;
    endcase
    return v;
  endfunction

`ifdef KEYSCAN_MULTI_REJECT_EN
  logic w_multi;
  assign w_multi    = |(r_col_s & (r_col_s - 4'd1));
  assign w_press_ok = (r_col_s != 4'd0) && !w_multi;
  assign w_match    = (r_col_s == r_cand) && !w_multi;
`else
  assign w_press_ok = (r_col_s != 4'd0);
  assign w_match    = (r_col_s == r_cand);
`endif

  assign w_cand_idx = f_enc(r_cand);
  // Only the accepted column is watched once held: no rollover.
  assign w_mon      = r_col_s[w_cand_idx];

  always_comb begin
    w_state_nxt   = r_state;
    w_scan_nxt    = r_scan_cnt;
    w_deb_nxt     = r_deb_cnt;
    w_row_idx_nxt = r_row_idx;
    w_cand_nxt    = r_cand;
    w_code_nxt    = r_code;
    w_valid_nxt   = 1'b0;
    w_held_nxt    = r_held;
    case (r_state)
      SCAN: begin
        // First two counts of a row see stale synchronizer data.
        if (r_scan_cnt >= LP_BLANK && w_press_ok) begin
          w_state_nxt = PRESS_DB;
          w_cand_nxt  = r_col_s;
          w_deb_nxt   = '0;
        end else if (r_scan_cnt == LP_SCAN_TC) begin
          w_scan_nxt    = '0;
          w_row_idx_nxt = r_row_idx + 2'd1;
        end else begin
          w_scan_nxt = r_scan_cnt + 1'b1;
        end
      end
      PRESS_DB: begin
        if (!w_match) begin
          w_state_nxt = SCAN;
          w_scan_nxt  = '0;
        end else if (r_deb_cnt == LP_DEB_TC) begin
          w_state_nxt = HELD;
          w_code_nxt  = {r_row_idx, w_cand_idx};
          w_valid_nxt = 1'b1;
          w_held_nxt  = 1'b1;
        end else begin
          w_deb_nxt = r_deb_cnt + 1'b1;
        end
      end
      HELD: begin
        if (!w_mon) begin
          w_state_nxt = REL_DB;
          w_deb_nxt   = '0;
        end
      end
      REL_DB: begin
        if (w_mon) begin
          w_state_nxt = HELD;
        end else if (r_deb_cnt == LP_DEB_TC) begin
          w_state_nxt   = SCAN;
          w_held_nxt    = 1'b0;
          w_row_idx_nxt = r_row_idx + 2'd1;
          w_scan_nxt    = '0;
        end else begin
          w_deb_nxt = r_deb_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = SCAN;
        w_scan_nxt  = '0;
        w_deb_nxt   = '0;
        w_held_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1    <= 4'd0;
      r_col_s    <= 4'd0;
      r_state    <= SCAN;
      r_scan_cnt <= '0;
      r_deb_cnt  <= '0;
      r_row_idx  <= 2'd0;
      r_row      <= 4'b0001;
      r_cand     <= 4'd0;
      r_code     <= 4'h0;
      r_valid    <= 1'b0;
      r_held     <= 1'b0;
    end else begin
      r_sync1    <= col;
      r_col_s    <= r_sync1;
      r_state    <= w_state_nxt;
      r_scan_cnt <= w_scan_nxt;
      r_deb_cnt  <= w_deb_nxt;
      r_row_idx  <= w_row_idx_nxt;
      r_row      <= 4'b0001 << w_row_idx_nxt;
      r_cand     <= w_cand_nxt;
      r_code     <= w_code_nxt;
      r_valid    <= w_valid_nxt;
      r_held     <= w_held_nxt;
    end
  end

  assign row       = r_row;
  assign row_idx   = r_row_idx;
  assign key_code  = r_code;
  assign key_valid = r_valid;
  assign key_held  = r_held;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed stimulus with a queue scoreboard for keypad_scanner.
// Expected key pulses are queued by stimulus and checked by a separate monitor.
module tb_keypad_scanner;

  logic       clk;
  logic       reset;
  logic [3:0] col;
  logic [3:0] row;
  logic [1:0] row_idx;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  int n_pass;
  int n_tot;
  int cyc;

  typedef struct {
    logic [3:0] code;
    int         at;
  } exp_t;

  exp_t q[$];

  keypad_scanner #(
    .SCAN_DIV(4),
    .DEBOUNCE_CYCLES(8),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .col(col),
    .row(row),
    .row_idx(row_idx),
    .key_code(key_code),
    .key_valid(key_valid),
    .key_held(key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Return at the first negedge on which row r is driven.
  task automatic wait_row(input logic [1:0] r);
    logic [1:0] prev;
    int n;
    bit found;
    prev = row_idx;
    n = 0;
    found = 0;
    while (!found && n < 64) begin
      @(negedge clk);
      if (row_idx == r && prev != r) found = 1;
      prev = row_idx;
      n++;
    end
    if (!found) begin
      n_tot++;
      $display("FAIL wait_row: row %0d not reached in 64 cycles", r);
    end
  endtask

  // Monitor: every key_valid must match the head of the queue.
  always @(negedge clk) begin
    if (reset && key_valid) begin
      if (q.size() == 0) begin
        n_tot++;
        $display("FAIL unexpected_pulse: got code %0h expected no pulse",
                 key_code);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("pulse_code", int'(key_code), int'(e.code));
        if (e.at >= 0) chk("pulse_cycle", cyc, e.at);
      end
    end
  end

  initial begin
    logic [3:0] er;
    exp_t e;
    n_pass = 0;
    n_tot  = 0;
    reset  = 1'b0;
    col    = 4'd0;
    tick(3);
    chk("rst_row", int'(row), 1);
    chk("rst_row_idx", int'(row_idx), 0);
    chk("rst_code", int'(key_code), 0);
    chk("rst_valid", int'(key_valid), 0);
    chk("rst_held", int'(key_held), 0);

    // 1: idle scan, each row for 4 clocks
    reset = 1'b1;
    for (int j = 0; j < 20; j++) begin
      er = 4'b0001 << ((j / 4) % 4);
      chk("scan_row_idx", int'(row_idx), (j / 4) % 4);
      chk("scan_row", int'(row), int'(er));
      tick(1);
    end
    chk("scan_code", int'(key_code), 0);

    // 2: clean press on row 2, column 2
    wait_row(2'd2);
    col = 4'b0100;
    e.code = 4'hA;
    e.at = cyc + 10;
    q.push_back(e);
    tick(30);
    chk("t2_held", int'(key_held), 1);
    chk("t2_row", int'(row), 4'b0100);
    col = 4'd0;
    tick(9);
    chk("t2_held_pre_rel", int'(key_held), 1);
    tick(1);
    chk("t2_released", int'(key_held), 0);
    chk("t2_row_next", int'(row_idx), 3);
    chk("t2_code_kept", int'(key_code), 4'hA);

    // 3: bouncing press on row 1
    wait_row(2'd1);
    for (int i = 0; i < 20; i++) begin
      col = ((i / 3) % 2 == 0) ? 4'b0100 : 4'b0000;
      tick(1);
    end
    col = 4'b0100;
    e.code = 4'h6;
    e.at = -1;
    q.push_back(e);
    tick(12);
    chk("t3_held", int'(key_held), 1);
    chk("t3_row", int'(row), 4'b0010);

    // 4: bouncing release of held key 6
    for (int i = 0; i < 12; i++) begin
      col = ((i / 3) % 2 == 0) ? 4'b0000 : 4'b0100;
      tick(1);
    end
    chk("t4_held_bounce", int'(key_held), 1);
    col = 4'd0;
    tick(9);
    chk("t4_held_pre_rel", int'(key_held), 1);
    tick(1);
    chk("t4_released", int'(key_held), 0);
    chk("t4_row_idx", int'(row_idx), 2);
    chk("t4_code", int'(key_code), 4'h6);

    // 5: reset in the middle of press debounce
    wait_row(2'd0);
    col = 4'b0001;
    tick(8);
    reset = 1'b0;
    #1;
    chk("t5_row", int'(row), 1);
    chk("t5_row_idx", int'(row_idx), 0);
    chk("t5_code", int'(key_code), 0);
    chk("t5_valid", int'(key_valid), 0);
    chk("t5_held", int'(key_held), 0);
    tick(1);
    col = 4'd0;
    tick(3);
    reset = 1'b1;
    tick(20);
    chk("t5_code_after", int'(key_code), 0);
    chk("t5_held_after", int'(key_held), 0);

    // 6: two columns at once on row 3
    wait_row(2'd3);
    col = 4'b1010;
`ifndef KEYSCAN_MULTI_REJECT_EN
    e.code = 4'hF;
    e.at = cyc + 10;
    q.push_back(e);
`endif
    tick(14);
`ifdef KEYSCAN_MULTI_REJECT_EN
    chk("t6_held", int'(key_held), 0);
    chk("t6_code", int'(key_code), 0);
`else
    chk("t6_held", int'(key_held), 1);
    chk("t6_code", int'(key_code), 4'hF);
`endif
    col = 4'd0;
    tick(12);
    chk("t6_released", int'(key_held), 0);

    tick(5);
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
